// File: rtl/arbiter.sv
// Centralised fixed-priority bus arbiter with one serial line per master in
// each direction. Master 0 has the highest priority.
// Build option: define ARBITER_PREEMPT_EN to let a higher-priority pending
// master force the current owner to split its transaction (HOLD frame).
`timescale 1ns/1ps

module arbiter #(
    parameter int NO_MASTERS = 2,
    parameter int NO_SLAVES  = 3,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
    parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
) (
    input  logic                             clk,
    input  logic                             rstN,
    input  logic                             port_in  [NO_MASTERS],
    output logic                             port_out [NO_MASTERS],
    output logic                             ready,
    output logic [S_ID_WIDTH+M_ID_WIDTH-1:0] bus_state
);

    localparam int         CNT_W      = $clog2(S_ID_WIDTH) + 1;
    localparam logic [1:0] CODE_GRANT = 2'b01;
    localparam logic [1:0] CODE_OVER  = 2'b11;
    localparam logic [1:0] CODE_DONE  = 2'b10;
`ifdef ARBITER_PREEMPT_EN
    localparam logic [1:0] CODE_HOLD  = 2'b10;
`endif

    typedef enum logic [3:0] {
        RX_IDLE, RX_S1, RX_REQ2, RX_ID, RX_STOP, RX_ACK2, RX_COM, RX_C1, RX_C2, RX_C3
    } rx_state_t;

    typedef enum logic [2:0] {IDLE, GRANT, WAIT_ACK, BUSY, PREEMPT} arb_state_t;

    // Frame events are decoded on the very bit that completes the frame so
    // the arbiter can react on the same clock edge.
    logic [NO_MASTERS-1:0]                 req_evt, ack_evt, over_evt, done_evt;
    logic [NO_MASTERS-1:0][S_ID_WIDTH-1:0] req_id;

    for (genvar i = 0; i < NO_MASTERS; i++) begin : g_rx
        rx_state_t             rx_state;
        logic [S_ID_WIDTH-1:0] rx_id;
        logic [CNT_W-1:0]      rx_cnt;
        logic [1:0]            rx_code;

        // Walk the incoming bit sequence; any unexpected bit drops back to idle
        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                rx_state <= RX_IDLE;
                rx_id    <= '0;
                rx_cnt   <= '0;
                rx_code  <= '0;
            end else begin
                case (rx_state)
                    RX_IDLE: if (port_in[i]) rx_state <= RX_S1;
                    RX_S1:   rx_state <= port_in[i] ? RX_REQ2 : RX_ACK2;
                    RX_REQ2: begin
                        rx_cnt   <= '0;
                        rx_state <= port_in[i] ? RX_ID : RX_IDLE;
                    end
                    RX_ID: begin
                        rx_id <= (rx_id << 1) | S_ID_WIDTH'(port_in[i]);
                        if (rx_cnt == CNT_W'(S_ID_WIDTH - 1)) rx_state <= RX_STOP;
                        else                                  rx_cnt   <= rx_cnt + 1'b1;
                    end
                    RX_STOP: rx_state <= RX_IDLE;
                    RX_ACK2: rx_state <= port_in[i] ? RX_COM : RX_IDLE;
                    RX_COM:  if (!port_in[i]) rx_state <= RX_C1;
                    RX_C1: begin
                        rx_code[1] <= port_in[i];
                        rx_state   <= RX_C2;
                    end
                    RX_C2: begin
                        rx_code[0] <= port_in[i];
                        rx_state   <= RX_C3;
                    end
                    RX_C3:   rx_state <= RX_IDLE;
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end

        assign req_evt[i]  = (rx_state == RX_STOP) && !port_in[i] && (rx_id != '0);
        assign req_id[i]   = rx_id;
        assign ack_evt[i]  = (rx_state == RX_ACK2) && port_in[i];
        assign over_evt[i] = (rx_state == RX_C3) && !port_in[i] && (rx_code == CODE_OVER);
        assign done_evt[i] = (rx_state == RX_C3) && !port_in[i] && (rx_code == CODE_DONE);
    end

    arb_state_t                            state;
    logic [NO_MASTERS-1:0]                 pending, held;
    logic [NO_MASTERS-1:0][S_ID_WIDTH-1:0] saved_id;
    logic [M_ID_WIDTH-1:0]                 owner;
    logic [NO_MASTERS-1:0][1:0]            tx_bits;
    logic [NO_MASTERS-1:0][1:0]            tx_cnt;
    logic [NO_MASTERS-1:0]                 tx_busy;
    logic [NO_MASTERS-1:0]                 fresh, cand;
    logic                                  sel_valid;
    logic [M_ID_WIDTH-1:0]                 sel;
    logic [S_ID_WIDTH-1:0]                 sel_slave;

    // A transmitter is busy until its frame has ended and the line is back at 0
    always_comb begin
        tx_busy = '0;
        for (int i = 0; i < NO_MASTERS; i++)
            tx_busy[i] = (tx_cnt[i] != 2'd0) || port_out[i];
    end

    // Pick the next master: fresh requests first, then split transactions resume
    always_comb begin
        fresh     = pending | req_evt;
        cand      = (fresh != '0) ? fresh : held;
        sel_valid = (cand != '0);
        sel       = '0;
        for (int i = NO_MASTERS - 1; i >= 0; i--)
            if (cand[i]) sel = M_ID_WIDTH'(i);
        sel_slave = req_evt[sel] ? req_id[sel] : saved_id[sel];
    end

`ifdef ARBITER_PREEMPT_EN
    logic preempt_req;

    // Flag any pending master that outranks the current owner
    always_comb begin
        preempt_req = 1'b0;
        for (int i = 0; i < NO_MASTERS; i++)
            if (pending[i] && (M_ID_WIDTH'(i) < owner)) preempt_req = 1'b1;
    end
`endif

    // Arbitration FSM plus the per-master frame transmitters
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            pending   <= '0;
            held      <= '0;
            saved_id  <= '0;
            owner     <= '0;
            tx_bits   <= '0;
            tx_cnt    <= '0;
            ready     <= 1'b0;
            bus_state <= '0;
            for (int i = 0; i < NO_MASTERS; i++) port_out[i] <= 1'b0;
        end else begin
            for (int i = 0; i < NO_MASTERS; i++) begin
                if (tx_cnt[i] != 2'd0) begin
                    port_out[i] <= tx_bits[i][1];
                    tx_bits[i]  <= {tx_bits[i][0], 1'b0};
                    tx_cnt[i]   <= tx_cnt[i] - 2'd1;
                end else begin
                    port_out[i] <= 1'b0;
                end
                if (req_evt[i]) begin
                    pending[i]  <= 1'b1;
                    saved_id[i] <= req_id[i];
                end
            end

            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        owner        <= sel;
                        bus_state    <= {sel, sel_slave};
                        pending[sel] <= 1'b0;
                        held[sel]    <= 1'b0;
                        if (!tx_busy[sel]) begin
                            port_out[sel] <= 1'b1;
                            tx_bits[sel]  <= CODE_GRANT;
                            tx_cnt[sel]   <= 2'd2;
                            state         <= WAIT_ACK;
                        end else begin
                            state <= GRANT;
                        end
                    end
                end
                GRANT: begin
                    if (!tx_busy[owner]) begin
                        port_out[owner] <= 1'b1;
                        tx_bits[owner]  <= CODE_GRANT;
                        tx_cnt[owner]   <= 2'd2;
                        state           <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_evt[owner]) begin
                        ready <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (over_evt[owner]) begin
                        ready          <= 1'b0;
                        bus_state      <= '0;
                        pending[owner] <= 1'b0;
                        state          <= IDLE;
                    end else if (done_evt[owner]) begin
                        ready           <= 1'b0;
                        held[owner]     <= 1'b1;
                        saved_id[owner] <= bus_state[S_ID_WIDTH-1:0];
                        bus_state       <= '0;
                        state           <= IDLE;
`ifdef ARBITER_PREEMPT_EN
                    end else if (preempt_req && !tx_busy[owner]) begin
                        port_out[owner] <= 1'b1;
                        tx_bits[owner]  <= CODE_HOLD;
                        tx_cnt[owner]   <= 2'd2;
                        state           <= PREEMPT;
`endif
                    end
                end
`ifdef ARBITER_PREEMPT_EN
                PREEMPT: begin
                    if (over_evt[owner]) begin
                        ready          <= 1'b0;
                        bus_state      <= '0;
                        pending[owner] <= 1'b0;
                        state          <= IDLE;
                    end else if (done_evt[owner]) begin
                        ready           <= 1'b0;
                        held[owner]     <= 1'b1;
                        saved_id[owner] <= bus_state[S_ID_WIDTH-1:0];
                        bus_state       <= '0;
                        state           <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter.sv
// Directed testbench for the serial-line bus arbiter (2 masters, 3 slaves).
`timescale 1ns/1ps

module tb_arbiter;

    logic       clk;
    logic       rstN;
    logic       port_in  [2];
    logic       port_out [2];
    logic       ready;
    logic [2:0] bus_state;

    logic [1:0] line_level;
    int         vectors;
    int         miscompares;

    localparam logic [7:0] ACK  = 8'b0000_0101;
    localparam logic [7:0] OVER = 8'b0000_0110;
    localparam logic [7:0] DONE = 8'b0000_0100;

    arbiter dut (
        .clk      (clk),
        .rstN     (rstN),
        .port_in  (port_in),
        .port_out (port_out),
        .ready    (ready),
        .bus_state(bus_state)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a stuck run still terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] req_frame(input logic [1:0] id);
        return {2'b00, 3'b111, id, 1'b0};
    endfunction

    // Drive both lines for one bit time, then settle just after the sampling edge
    task automatic applyStimulus(input logic b0, input logic b1);
        @(negedge clk);
        port_in[0] = b0;
        port_in[1] = b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) applyStimulus(line_level[0], line_level[1]);
    endtask

    task automatic send_bits(input int m, input logic [7:0] pattern, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            line_level[m] = pattern[k];
            applyStimulus(line_level[0], line_level[1]);
        end
    endtask

    task automatic send_both(input logic [7:0] p0, input logic [7:0] p1, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            line_level = {p1[k], p0[k]};
            applyStimulus(line_level[0], line_level[1]);
        end
    endtask

    // Compare {port_out[0], port_out[1], ready, bus_state} with the expected word
    task automatic checkOutput(input string tag, input logic [5:0] expected);
        logic [5:0] observed;
        observed = {port_out[0], port_out[1], ready, bus_state};
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Directed sequence
    initial begin
        vectors     = 0;
        miscompares = 0;
        rstN        = 1'b0;
        line_level  = '0;
        port_in[0]  = 1'b0;
        port_in[1]  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 6'b00_0_000);
        rstN = 1'b1;

        // A request for slave 0 is not a request
        send_bits(0, req_frame(2'b00), 6);
        checkOutput("req_id0_ignored", 6'b00_0_000);
        idle_cycles(2);
        checkOutput("req_id0_no_grant", 6'b00_0_000);

        // Single transaction: master1 to slave 01
        send_bits(1, req_frame(2'b01), 6);
        checkOutput("single_grant_bit0", 6'b01_0_101);
        idle_cycles(1);
        checkOutput("single_grant_bit1", 6'b00_0_101);
        idle_cycles(1);
        checkOutput("single_grant_bit2", 6'b01_0_101);
        idle_cycles(1);
        checkOutput("single_grant_end", 6'b00_0_101);
        send_bits(1, 8'b10, 2);
        checkOutput("single_ack_partial", 6'b00_0_101);
        send_bits(1, 8'b1, 1);
        checkOutput("single_ready", 6'b00_1_101);
        idle_cycles(2);
        checkOutput("single_com", 6'b00_1_101);
        send_bits(1, 8'b011, 3);
        checkOutput("single_over_partial", 6'b00_1_101);
        send_bits(1, 8'b0, 1);
        checkOutput("single_over", 6'b00_0_000);

        // Back-to-back: master1 slave 10, then master0 slave 11
        send_bits(1, req_frame(2'b10), 6);
        checkOutput("b2b_grant_m1", 6'b01_0_110);
        idle_cycles(3);
        send_bits(1, ACK, 3);
        checkOutput("b2b_ready_m1", 6'b00_1_110);
        idle_cycles(1);
        send_bits(1, OVER, 4);
        checkOutput("b2b_over_m1", 6'b00_0_000);
        send_bits(0, req_frame(2'b11), 6);
        checkOutput("b2b_grant_m0", 6'b10_0_011);
        idle_cycles(3);
        send_bits(0, ACK, 3);
        checkOutput("b2b_ready_m0", 6'b00_1_011);
        send_bits(0, OVER, 4);
        checkOutput("b2b_over_m0", 6'b00_0_000);

        // Simultaneous stop bits: master0 (slave 10) wins, master1 (slave 01) waits
        send_both(req_frame(2'b10), req_frame(2'b01), 6);
        checkOutput("simul_grant_m0", 6'b10_0_010);
        idle_cycles(3);
        send_bits(0, ACK, 3);
        checkOutput("simul_ready_m0", 6'b00_1_010);
        send_bits(0, OVER, 4);
        checkOutput("simul_over_m0", 6'b00_0_000);
        idle_cycles(1);
        checkOutput("simul_grant_m1", 6'b01_0_101);
        idle_cycles(3);
        send_bits(1, ACK, 3);
        checkOutput("simul_ready_m1", 6'b00_1_101);
        send_bits(1, OVER, 4);
        checkOutput("simul_over_m1", 6'b00_0_000);

        // Voluntary split: master0 gives way to master1, then resumes
        send_bits(0, req_frame(2'b01), 6);
        checkOutput("split_grant_m0", 6'b10_0_001);
        idle_cycles(3);
        send_bits(0, ACK, 3);
        checkOutput("split_ready_m0", 6'b00_1_001);
        send_bits(1, req_frame(2'b11), 6);
        checkOutput("split_m1_waits", 6'b00_1_001);
        send_bits(0, DONE, 4);
        checkOutput("split_done_m0", 6'b00_0_000);
        idle_cycles(1);
        checkOutput("split_grant_m1", 6'b01_0_111);
        idle_cycles(3);
        send_bits(1, ACK, 3);
        checkOutput("split_ready_m1", 6'b00_1_111);
        send_bits(1, OVER, 4);
        checkOutput("split_over_m1", 6'b00_0_000);
        idle_cycles(1);
        checkOutput("split_regrant_m0", 6'b10_0_001);
        idle_cycles(3);
        send_bits(0, ACK, 3);
        checkOutput("split_resume_m0", 6'b00_1_001);
        send_bits(0, OVER, 4);
        checkOutput("split_over_m0", 6'b00_0_000);

        // Higher-priority request while master1 owns slave 01
        send_bits(1, req_frame(2'b01), 6);
        checkOutput("pre_grant_m1", 6'b01_0_101);
        idle_cycles(3);
        send_bits(1, ACK, 3);
        checkOutput("pre_ready_m1", 6'b00_1_101);
        send_bits(0, req_frame(2'b01), 6);
        checkOutput("pre_req_m0", 6'b00_1_101);
`ifdef ARBITER_PREEMPT_EN
        idle_cycles(1);
        checkOutput("pre_hold_bit0", 6'b01_1_101);
        idle_cycles(1);
        checkOutput("pre_hold_bit1", 6'b01_1_101);
        idle_cycles(1);
        checkOutput("pre_hold_bit2", 6'b00_1_101);
        send_bits(1, DONE, 4);
        checkOutput("pre_done_m1", 6'b00_0_000);
        idle_cycles(1);
        checkOutput("pre_grant_m0", 6'b10_0_001);
        idle_cycles(3);
        send_bits(0, ACK, 3);
        checkOutput("pre_ready_m0", 6'b00_1_001);
        send_bits(0, OVER, 4);
        checkOutput("pre_over_m0", 6'b00_0_000);
        idle_cycles(1);
        checkOutput("pre_regrant_m1", 6'b01_0_101);
        idle_cycles(3);
        send_bits(1, ACK, 3);
        checkOutput("pre_ready_m1_again", 6'b00_1_101);
        send_bits(1, OVER, 4);
        checkOutput("pre_over_m1", 6'b00_0_000);
`else
        idle_cycles(3);
        checkOutput("nopre_no_hold", 6'b00_1_101);
        send_bits(1, OVER, 4);
        checkOutput("nopre_over_m1", 6'b00_0_000);
        idle_cycles(1);
        checkOutput("nopre_grant_m0", 6'b10_0_001);
        idle_cycles(3);
        send_bits(0, ACK, 3);
        checkOutput("nopre_ready_m0", 6'b00_1_001);
        send_bits(0, OVER, 4);
        checkOutput("nopre_over_m0", 6'b00_0_000);
`endif

        // Reset in the middle of a transaction clears everything at once
        send_bits(0, req_frame(2'b10), 6);
        checkOutput("rst_grant_m0", 6'b10_0_010);
        idle_cycles(3);
        send_bits(0, ACK, 3);
        checkOutput("rst_busy", 6'b00_1_010);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("rst_async_clear", 6'b00_0_000);
        line_level = '0;
        port_in[0] = 1'b0;
        port_in[1] = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        send_bits(1, req_frame(2'b11), 6);
        checkOutput("rst_regrant_m1", 6'b01_0_111);
        idle_cycles(3);
        send_bits(1, ACK, 3);
        checkOutput("rst_ready_m1", 6'b00_1_111);
        send_bits(1, OVER, 4);
        checkOutput("rst_over_m1", 6'b00_0_000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
